// File: rtl/usb_pid_token_decoder.sv
// Receive-side USB packet decoder: validates the PID byte, classifies the packet,
// collects and CRC5-checks token payloads, and reports outcomes as one-cycle pulses.
module usb_pid_token_decoder #(
  parameter bit ADDR_FILTER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] dev_addr,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic       tok_valid,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       hs_valid,
  output logic       data_start,
  output logic [3:0] pid_out,
  output logic       err_pid,
  output logic       err_crc5,
  output logic       err_len
);

  localparam int unsigned CRC_W    = 5;
  localparam int unsigned BYTE_W   = 8;
  localparam logic [CRC_W-1:0] CRC_INIT = 5'b11111;
  localparam logic [CRC_W-1:0] CRC_POLY = 5'b00101;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  typedef enum logic [1:0] {CLS_SPECIAL, CLS_TOKEN, CLS_DATA, CLS_HS} pid_cls_e;
  typedef enum logic [2:0] {S_IDLE, S_PID, S_HS, S_TOK1, S_TOK2, S_TOKEOP, S_SKIP} state_e;

  state_e           r_state;
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] r_crc_rx;
  logic [6:0]       r_addr;
  logic [3:0]       r_endp;
  logic [3:0]       r_pid;
  logic             r_len_err;
  logic             r_rx_active_d;

  pid_cls_e w_cls;
  logic     w_rise;
  logic     w_pid_take;
  logic     w_pid_ok;
  logic     w_crc_ok;
  logic     w_addr_drop;

  // Serial CRC5 over the low n bits of d, LSB first.
  function automatic logic [CRC_W-1:0] crc5_fold(input logic [CRC_W-1:0] c,
                                                 input logic [BYTE_W-1:0] d,
                                                 input int n);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      if (i < n) begin
        fb = d[i] ^ r[CRC_W-1];
        r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
      end
    end
    return r;
  endfunction

  always_comb begin
    w_cls = CLS_SPECIAL;
    case (rx_data[3:0])
      PID_OUT, PID_IN, PID_SOF, PID_SETUP:       w_cls = CLS_TOKEN;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: w_cls = CLS_DATA;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:      w_cls = CLS_HS;
      default:                                    w_cls = CLS_SPECIAL;
    endcase
  end

  // The PID byte may arrive in the same cycle rx_active rises.
  assign w_rise      = rx_active && !r_rx_active_d;
  assign w_pid_take  = rx_valid && ((r_state == S_PID) || ((r_state == S_IDLE) && w_rise));
  assign w_pid_ok    = (rx_data[7:4] == ~rx_data[3:0]);
  assign w_crc_ok    = (r_crc_rx == ~{r_crc[0], r_crc[1], r_crc[2], r_crc[3], r_crc[4]});
  assign w_addr_drop = ADDR_FILTER && (r_pid != PID_SOF) && (r_addr != dev_addr);

  // rx_active history resets high so a packet cut by reset is never picked up mid-stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_crc         <= CRC_INIT;
      r_crc_rx      <= '0;
      r_addr        <= '0;
      r_endp        <= '0;
      r_pid         <= '0;
      r_len_err     <= 1'b0;
      r_rx_active_d <= 1'b1;
      tok_valid     <= 1'b0;
      tok_pid       <= '0;
      tok_addr      <= '0;
      tok_endp      <= '0;
      hs_valid      <= 1'b0;
      data_start    <= 1'b0;
      pid_out       <= '0;
      err_pid       <= 1'b0;
      err_crc5      <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      r_rx_active_d <= rx_active;
      tok_valid     <= 1'b0;
      hs_valid      <= 1'b0;
      data_start    <= 1'b0;
      err_pid       <= 1'b0;
      err_crc5      <= 1'b0;
      err_len       <= 1'b0;

      if ((r_state != S_IDLE) && rx_error) begin
        r_len_err <= 1'b0;
        r_state   <= S_SKIP;
      end else if (w_pid_take) begin
        r_crc     <= CRC_INIT;
        r_len_err <= 1'b0;
        r_pid     <= rx_data[3:0];
        if (!w_pid_ok) begin
          err_pid <= 1'b1;
          r_state <= S_SKIP;
        end else begin
          case (w_cls)
            CLS_TOKEN: r_state <= S_TOK1;
            CLS_HS:    r_state <= S_HS;
            CLS_DATA: begin
              data_start <= 1'b1;
              pid_out    <= rx_data[3:0];
              r_state    <= S_SKIP;
            end
            default:   r_state <= S_SKIP;
          endcase
        end
      end else begin
        case (r_state)
          S_IDLE: if (w_rise) r_state <= S_PID;
          S_PID:  if (!rx_active) r_state <= S_IDLE;
          S_HS: begin
            if (!rx_active) begin
              hs_valid <= 1'b1;
              pid_out  <= r_pid;
              r_state  <= S_IDLE;
            end else if (rx_valid) begin
              r_len_err <= 1'b1;
              r_state   <= S_SKIP;
            end
          end
          S_TOK1: begin
            if (!rx_active) begin
              err_len <= 1'b1;
              r_state <= S_IDLE;
            end else if (rx_valid) begin
              r_crc     <= crc5_fold(r_crc, rx_data, 8);
              r_addr    <= rx_data[6:0];
              r_endp[0] <= rx_data[7];
              r_state   <= S_TOK2;
            end
          end
          S_TOK2: begin
            if (!rx_active) begin
              err_len <= 1'b1;
              r_state <= S_IDLE;
            end else if (rx_valid) begin
              r_crc       <= crc5_fold(r_crc, rx_data, 3);
              r_crc_rx    <= rx_data[7:3];
              r_endp[3:1] <= rx_data[2:0];
              r_state     <= S_TOKEOP;
            end
          end
          S_TOKEOP: begin
            if (!rx_active) begin
              if (!w_crc_ok) begin
                err_crc5 <= 1'b1;
              end else if (!w_addr_drop) begin
                tok_valid <= 1'b1;
                tok_pid   <= r_pid;
                tok_addr  <= r_addr;
                tok_endp  <= r_endp;
                pid_out   <= r_pid;
              end
              r_state <= S_IDLE;
            end else if (rx_valid) begin
              r_len_err <= 1'b1;
              r_state   <= S_SKIP;
            end
          end
          S_SKIP: begin
            if (!rx_active) begin
              err_len   <= r_len_err;
              r_len_err <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/usb_pid_token_decoder.md
# usb_pid_token_decoder

Receive-side packet decoder between the byte-level receiver (NRZI decode, bit unstuffing, deserialisation) and the SIE control logic. It checks the PID byte of every received packet and classifies the packet as token, data, handshake or special. For token packets it collects the two payload bytes, verifies CRC5 and filters on device address. It reports results as single-cycle pulses carrying `types::pid_t` and `token_t`-style fields, plus error flags matching the `usb_status_t` bits `pid`, `crc5` and `token_done`.

## Interface
Parameters:
- `ADDR_FILTER`, default 1: 1 = IN/OUT/SETUP tokens are reported only when the address equals `dev_addr`; 0 = all tokens are reported.

Ports:
- `clk` — in, 1: single clock; all logic on the rising edge.
- `rst_n` — in, 1: asynchronous, active-low reset.
- `dev_addr` — in, 7: assigned device address.
- `rx_active` — in, 1: high from SYNC end through the last byte; falling edge = EOP.
- `rx_valid` — in, 1: `rx_data` valid this cycle; at most one byte per cycle, only while `rx_active`.
- `rx_data` — in, 8: received byte, LSB = first bit on the wire.
- `rx_error` — in, 1: receiver error (stuff or align); aborts the current packet.
- `tok_valid` — out, 1: one-cycle pulse, a good token was accepted.
- `tok_pid` — out, 4 (`pid_t`): OUT, IN, SETUP or SOF.
- `tok_addr` — out, 7: token address (for SOF: `frame[6:0]`).
- `tok_endp` — out, 4: token endpoint (for SOF: `frame[10:7]`).
- `hs_valid` — out, 1: one-cycle pulse, a good handshake (ACK/NAK/STALL/NYET) was received.
- `data_start` — out, 1: one-cycle pulse after a good DATA0/1/2/MDATA PID byte.
- `pid_out` — out, 4: PID of the last good packet; held until the next one.
- `err_pid` — out, 1: one-cycle pulse, PID check failure.
- `err_crc5` — out, 1: one-cycle pulse, CRC5 mismatch.
- `err_len` — out, 1: one-cycle pulse, wrong byte count for the PID class.

## Operation
- Reset (`rst_n` = 0, asynchronous): FSM to IDLE, CRC register = 5'b11111, all outputs 0. Reset mid-packet drops the packet with no pulses.
- FSM states: IDLE, PID, TOK1, TOK2, TOKEOP, SKIP.
  - IDLE: on `rx_active` rise → PID.
  - PID: on first `rx_valid`, check `rx_data[7:4] == ~rx_data[3:0]`.
    - Check fails → pulse `err_pid`, go to SKIP.
    - Token PID (OUT, IN, SETUP, SOF) → TOK1.
    - DATA0/1/2 or MDATA → pulse `data_start`, update `pid_out`, go to SKIP. Later bytes belong to the downstream data receiver.
    - Handshake PID → wait for EOP. EOP with no further byte → pulse `hs_valid`, update `pid_out`. An extra byte → `err_len`, go to SKIP.
    - PRE_ERR, SPLIT, PING, RESERVED → SKIP silently.
  - TOK1: byte1 = {`endp[0]`, `addr[6:0]`}; fold its 8 bits into the CRC, LSB first → TOK2.
  - TOK2: byte2 = {`crc5[4:0]`, `endp[3:1]`}; fold `byte2[2:0]` into the CRC → TOKEOP.
  - TOKEOP:
    - A 4th byte → `err_len`, go to SKIP.
    - EOP → compare CRC. Mismatch → `err_crc5`. Match → `tok_valid`, unless `ADDR_FILTER` = 1, the PID is not SOF, and `addr != dev_addr`; then no pulse and no error.
  - SKIP: ignore bytes until EOP, then IDLE.
- EOP (`rx_active` falling) in PID, TOK1 or TOK2 → `err_len` (except EOP in PID with no byte: silent), then IDLE.
- `rx_error` in any non-IDLE state → SKIP; no pulses for that packet; no `err_*` of its own.
- CRC5 (x^5+x^2+1):
  - Per bit b: `fb = b ^ c[4]`; `c = {c[3:0],0} ^ (fb ? 5'b00101 : 0)`.
  - Init 5'b11111 at the PID byte.
  - Good when `crc5[i] == ~c[4-i]` for i = 0..4 (bit-reversed complement).
- Token fields are registered and stable from the `tok_valid` cycle until the next `tok_valid`.

## Timing
- All pulses fire exactly one cycle after the cycle in which `rx_active` is first sampled low for token and handshake packets.
- `data_start` and `err_pid` fire one cycle after the PID byte's `rx_valid`.
- At most one of `tok_valid`, `hs_valid`, `data_start`, `err_*` is high per packet (`err_*` mutually exclusive).
- Back-to-back packets: `rx_active` may rise again in the cycle after a pulse; IDLE accepts it with no lost byte.
- Bytes may arrive with arbitrary gaps (`rx_valid` low) within a packet.

## Test plan
- SETUP, addr 0, ep 0: bytes 2D 00 10 then EOP, `dev_addr` = 0 → `tok_valid` one cycle after EOP, `tok_pid` = SETUP, addr 0, ep 0.
- Same bytes with `dev_addr` = 5 and `ADDR_FILTER` = 1 → no pulse at all; with byte 2 = 0x11 → `err_crc5` only.
- ACK byte D2 then EOP → `hs_valid`, `pid_out` = ACK. Byte D3 → `err_pid`. Bytes D2 00 → `err_len`.
- DATA1 byte 4B followed by 10 bytes → `data_start` one cycle after 4B, nothing at EOP; then 2D 00 10 back-to-back → `tok_valid`.
- `rx_error` after byte 2D, and separately `rst_n` pulsed low after byte 00 → no pulses; the next clean packet decodes correctly.
